// File: rtl/counter_pkg.sv
// Shared types and constants for the up/down modulo counter and its prescaler.
// Purely declarative: no logic, no latency, no backpressure.
package counter_pkg;

  typedef logic [1:0] speed_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam speed_t SPEED_1X = 2'd0;
  localparam speed_t SPEED_2X = 2'd1;
  localparam speed_t SPEED_4X = 2'd2;
  localparam speed_t SPEED_8X = 2'd3;

  // Each speed step halves the number of clock cycles per count.
  function automatic int tick_period(input int div_base, input speed_t speed);
    return div_base >> speed;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Count-enable generator: one-cycle tick every (DIV_BASE >> speed) running cycles, tick is combinational.
// No backpressure; run=0 freezes the phase, clear restarts it from zero at the next edge.
module tick_prescaler
  import counter_pkg::*;
#(
  parameter int DIV_BASE = 50_000_000
) (
  input  logic   clk,
  input  logic   reset_n,
  input  speed_t speed,
  input  logic   run,
  input  logic   clear,
  output logic   tick
);

  localparam int PW = $clog2(DIV_BASE);

  logic [PW-1:0] r_pre;
  logic [PW-1:0] w_limit;

  assign w_limit = PW'(tick_period(DIV_BASE, speed) - 1);
  assign tick    = run && (r_pre == w_limit);

  // clear wins so a speed change always starts a full new period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pre <= '0;
    end else if (clear) begin
      r_pre <= '0;
    end else if (tick) begin
      r_pre <= '0;
    end else if (run) begin
      r_pre <= r_pre + PW'(1);
    end
  end

endmodule

// File: rtl/updown_mod_counter.sv
// Modulo-MOD up/down counter with speed prescaler, pause and clamped load; q updates at the tick edge.
// No backpressure; tick and tc are combinational pulses for cascading the next digit.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int N        = 4,
  parameter int MOD      = 10,
  parameter int DIV_BASE = 50_000_000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         btn_ud,
  input  logic         btn_speed,
  input  logic         btn_pause,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] q,
  output logic         dir,
  output speed_t       speed,
  output logic         paused,
  output logic         tick,
  output logic         tc
);

  localparam logic [N-1:0] MAX_Q = N'(MOD - 1);
  localparam logic [N-1:0] ONE_Q = N'(1);

  logic [N-1:0] r_q;
  logic         r_dir;
  speed_t       r_speed;
  logic         r_paused;

  logic         w_run;
  logic         w_tick;
  logic         w_at_wrap;
  logic [N-1:0] w_step_q;
  logic [N-1:0] w_load_q;

  assign w_run = !r_paused;

  tick_prescaler #(
    .DIV_BASE(DIV_BASE)
  ) u_prescaler (
    .clk    (clk),
    .reset_n(reset_n),
    .speed  (r_speed),
    .run    (w_run),
    .clear  (btn_speed),
    .tick   (w_tick)
  );

  // Wrap is detected against MOD-1 explicitly so MOD < 2^N never relies on overflow.
  always_comb begin
    w_at_wrap = (r_dir == DIR_UP) ? (r_q == MAX_Q) : (r_q == '0);
    if (r_dir == DIR_UP) begin
      w_step_q = w_at_wrap ? '0 : (r_q + ONE_Q);
    end else begin
      w_step_q = w_at_wrap ? MAX_Q : (r_q - ONE_Q);
    end
    w_load_q = (32'(load_val) < MOD) ? load_val : MAX_Q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q      <= '0;
      r_dir    <= DIR_UP;
      r_speed  <= SPEED_1X;
      r_paused <= 1'b0;
    end else begin
      if (load) begin
        r_q <= w_load_q;
      end else if (w_tick) begin
        r_q <= w_step_q;
      end
      if (btn_ud) begin
        r_dir <= ~r_dir;
      end
      if (btn_speed) begin
        r_speed <= r_speed + 2'd1;
      end
      if (btn_pause) begin
        r_paused <= ~r_paused;
      end
    end
  end

  assign q      = r_q;
  assign dir    = r_dir;
  assign speed  = r_speed;
  assign paused = r_paused;
  assign tick   = w_tick;
  assign tc     = w_tick && !load && w_at_wrap;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench for updown_mod_counter (N=4, MOD=10, DIV_BASE=8): directed scenarios then random pulses.
// Driver pushes reference-model expectations; a negedge monitor pops and compares.
module tb_updown_mod_counter;

  localparam int N   = 4;
  localparam int MOD = 10;
  localparam int DIV = 8;

  typedef struct packed {
    logic [3:0] q;
    logic       dir;
    logic [1:0] speed;
    logic       paused;
    logic       tick;
    logic       tc;
  } obs_t;

  typedef struct {
    string name;
    obs_t  mask;
    obs_t  val;
    bit    timeout;
  } spot_t;

  localparam obs_t MK_ALL  = '1;
  localparam obs_t MK_Q    = 10'b1111_0_00_0_0_0;
  localparam obs_t MK_DIR  = 10'b0000_1_00_0_0_0;
  localparam obs_t MK_SPD  = 10'b0000_0_11_0_0_0;
  localparam obs_t MK_PAU  = 10'b0000_0_00_1_0_0;
  localparam obs_t MK_TICK = 10'b0000_0_00_0_1_0;
  localparam obs_t MK_TC   = 10'b0000_0_00_0_0_1;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         btn_ud = 1'b0;
  logic         btn_speed = 1'b0;
  logic         btn_pause = 1'b0;
  logic         load = 1'b0;
  logic [N-1:0] load_val = '0;
  logic [N-1:0] q;
  logic         dir;
  logic [1:0]   speed;
  logic         paused;
  logic         tick;
  logic         tc;

  updown_mod_counter #(.N(N), .MOD(MOD), .DIV_BASE(DIV)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .btn_ud   (btn_ud),
    .btn_speed(btn_speed),
    .btn_pause(btn_pause),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .dir      (dir),
    .speed    (speed),
    .paused   (paused),
    .tick     (tick),
    .tc       (tc)
  );

  always #5 clk = ~clk;

  obs_t  exp_q[$];
  spot_t spot_q[$];
  int    checks = 0;
  int    errors = 0;

  // Reference model: digit value, direction, speed level, pause flag and cycles elapsed in the current period.
  int m_q, m_speed, m_pre;
  bit m_dir, m_paused;

  function automatic obs_t mk(input int qv, input bit d, input int s, input bit p, input bit t, input bit c);
    return {4'(qv), d, 2'(s), p, t, c};
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("q=%0d dir=%0b speed=%0d paused=%0b tick=%0b tc=%0b",
                     o.q, o.dir, o.speed, o.paused, o.tick, o.tc);
  endfunction

  function automatic bit model_tick();
    return !m_paused && (m_pre == (DIV >> m_speed) - 1);
  endfunction

  task automatic m_reset();
    m_q = 0; m_dir = 1'b1; m_speed = 0; m_paused = 1'b0; m_pre = 0;
  endtask

  function automatic obs_t model_obs(input bit ld);
    bit t;
    bit wraps;
    t = model_tick();
    wraps = m_dir ? (m_q == MOD - 1) : (m_q == 0);
    return mk(m_q, m_dir, m_speed, m_paused, t, t && !ld && wraps);
  endfunction

  task automatic model_step(input bit ud, input bit sp, input bit pa, input bit ld, input int lv);
    bit t;
    t = model_tick();
    if (ld) m_q = (lv < MOD) ? lv : MOD - 1;
    else if (t) m_q = m_dir ? (m_q + 1) % MOD : (m_q + MOD - 1) % MOD;
    if (sp) m_pre = 0;
    else if (!m_paused) m_pre = t ? 0 : m_pre + 1;
    m_dir    = m_dir ^ ud;
    m_speed  = (m_speed + int'(sp)) % 4;
    m_paused = m_paused ^ pa;
  endtask

  task automatic drive(input bit rn, input bit ud, input bit sp, input bit pa, input bit ld, input int lv);
    @(posedge clk);
    #1;
    reset_n   = rn;
    btn_ud    = ud;
    btn_speed = sp;
    btn_pause = pa;
    load      = ld;
    load_val  = 4'(lv);
    if (!rn) m_reset();
    exp_q.push_back(model_obs(rn && ld));
    if (rn) model_step(ud, sp, pa, ld, lv);
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  task automatic spot(input string nm, input obs_t mask, input obs_t val);
    spot_q.push_back('{name: nm, mask: mask, val: val & mask, timeout: 1'b0});
  endtask

  task automatic spot_timeout(input string nm);
    spot_q.push_back('{name: nm, mask: '0, val: '0, timeout: 1'b1});
  endtask

  task automatic wait_next_tick(input string nm);
    int n;
    n = 0;
    while (!model_tick() && n < 64) begin
      idle();
      n++;
    end
    if (!model_tick()) spot_timeout(nm);
  endtask

  always @(negedge clk) begin
    obs_t  a;
    obs_t  e;
    spot_t s;
    a = {q, dir, speed, paused, tick, tc};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL model @%0t: got %s, required %s", $time, fmt(a), fmt(e));
      end
    end
    while (spot_q.size() > 0) begin
      s = spot_q.pop_front();
      checks++;
      if (s.timeout) begin
        errors++;
        $display("FAIL %s @%0t: wait bound expired", s.name, $time);
      end else if ((a & s.mask) !== s.val) begin
        errors++;
        $display("FAIL %s @%0t: got %s, required %s (mask %b)", s.name, $time, fmt(a), fmt(s.val), s.mask);
      end
    end
  end

  initial begin
    int n;
    m_reset();
    repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    spot("reset_state", MK_ALL, mk(0, 1, 0, 0, 0, 0));

    // Release, then ten ticks at period 8; the tenth wraps 9 -> 0 with tc.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    repeat (6) idle();
    spot("first_tick_not_early", MK_TICK | MK_Q, mk(0, 0, 0, 0, 0, 0));
    idle();
    spot("first_tick", MK_TICK | MK_Q | MK_TC, mk(0, 0, 0, 0, 1, 0));
    repeat (72) idle();
    spot("up_wrap_tc", MK_Q | MK_TICK | MK_TC, mk(9, 0, 0, 0, 1, 1));
    idle();
    spot("up_wrap_to_0", MK_Q | MK_TC, mk(0, 0, 0, 0, 0, 0));

    // Direction toggle at q=3: 2, 1, 0, 9 with tc only on 0 -> 9.
    n = 0;
    while (m_q != 3 && n < 200) begin idle(); n++; end
    if (m_q != 3) spot_timeout("reach_q3");
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    spot("ud_pre_edge", MK_DIR | MK_Q, mk(3, 1, 0, 0, 0, 0));
    repeat (31) idle();
    spot("down_wrap_tc", MK_Q | MK_DIR | MK_TICK | MK_TC, mk(0, 0, 0, 0, 1, 1));
    idle();
    spot("down_wrap_to_9", MK_Q | MK_TC, mk(9, 0, 0, 0, 0, 0));

    // Speed cycling: three pulses reach 8x, the fourth returns to period 8.
    repeat (3) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    idle();
    spot("speed3_tick_every_cycle", MK_SPD | MK_TICK, mk(0, 0, 3, 0, 1, 0));
    repeat (9) idle();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    repeat (7) idle();
    spot("speed0_no_early_tick", MK_SPD | MK_TICK, mk(0, 0, 0, 0, 0, 0));
    idle();
    spot("speed0_first_tick", MK_SPD | MK_TICK, mk(0, 0, 0, 0, 1, 0));

    // Pause at q=5, pre=3; resume ticks exactly 4 cycles after the second pulse.
    n = 0;
    while (!(m_q == 5 && m_pre == 3) && n < 400) begin idle(); n++; end
    if (!(m_q == 5 && m_pre == 3)) spot_timeout("reach_q5_pre3");
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    repeat (40) idle();
    spot("paused_hold", MK_Q | MK_PAU | MK_TICK, mk(5, 0, 0, 1, 0, 0));
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    repeat (3) idle();
    spot("resume_no_early_tick", MK_PAU | MK_TICK, mk(0, 0, 0, 0, 0, 0));
    idle();
    spot("resume_tick", MK_Q | MK_TICK, mk(5, 0, 0, 0, 1, 0));

    // Load priority over tick, clamping, and a tick after a load.
    wait_next_tick("reach_tick_for_load");
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 7);
    spot("load_tick_tc0", MK_TICK | MK_TC, mk(0, 0, 0, 0, 1, 0));
    idle();
    spot("load_7", MK_Q, mk(7, 0, 0, 0, 0, 0));
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12);
    idle();
    spot("load_clamp", MK_Q, mk(9, 0, 0, 0, 0, 0));
    if (m_dir) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9);
    wait_next_tick("reach_tick_after_load");
    idle();
    idle();
    spot("load_then_down", MK_Q | MK_DIR, mk(8, 0, 0, 0, 0, 0));

    // Build q=6, speed=2, dir=0, paused=1, then reset between edges.
    if (m_dir) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    drive(1'b1, 1'b0, 1'b0, !m_paused, 1'b1, 6);
    while (m_speed != 2) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    idle();
    spot("pre_reset_state", MK_ALL, mk(6, 0, 2, 1, 0, 0));
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    spot("async_reset_immediate", MK_ALL, mk(0, 1, 0, 0, 0, 0));
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    repeat (7) idle();
    spot("post_reset_period8", MK_Q | MK_SPD | MK_TICK, mk(0, 0, 0, 0, 1, 0));

    // Random pulses, loads and occasional resets against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 699) == 0) begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      end else begin
        drive(1'b1,
              $urandom_range(0, 15) == 0,
              $urandom_range(0, 23) == 0,
              $urandom_range(0, 19) == 0,
              $urandom_range(0, 29) == 0,
              int'($urandom_range(0, 15)));
      end
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised modulo-M up/down counter with a built-in speed prescaler, pause and synchronous load. It is the next generation of the team's free-running 2-bit counter. Button-derived single-cycle pulses control it: direction toggle, speed cycle and pause toggle. It sits between the debounce/edge-detect front end and the display decoder, and drives the digit value plus a terminal-count pulse for cascading the next digit.

## Interface
- `N`, 4: counter width in bits.
- `MOD`, 10: count range 0..MOD-1. Legal range 2 ≤ MOD ≤ 2^N.
- `DIV_BASE`, 50_000_000: clock cycles per count at speed 0. Must be a multiple of 8 and ≥ 8.
- `clk` input 1: single clock; all state on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `btn_ud` input 1: one-cycle pulse; toggles direction.
- `btn_speed` input 1: one-cycle pulse; advances speed 0→1→2→3→0.
- `btn_pause` input 1: one-cycle pulse; toggles pause.
- `load` input 1: synchronous load strobe.
- `load_val` input N: load value.
- `q` output N: count value.
- `dir` output 1: 1 = up, 0 = down.
- `speed` output 2: current speed level.
- `paused` output 1: 1 = counting frozen.
- `tick` output 1: count-enable pulse (combinational).
- `tc` output 1: terminal-count/wrap pulse (combinational).

## Operation
- **Reset values:** `q`=0, `dir`=1, `speed`=0, `paused`=0, prescaler=0, `tick`=0, `tc`=0.
- **Prescaler:** counter `pre`, width clog2(DIV_BASE).
  - Limit L = (DIV_BASE >> speed) − 1.
  - When not paused: `pre` increments each cycle.
  - `tick` = !paused && (pre == L); on a tick, `pre` ← 0.
  - When paused: `pre` holds and `tick`=0.
- **Counting:** on a `tick` cycle, `q` updates at that edge.
  - Up: `q`+1, wrapping MOD-1→0.
  - Down: `q`−1, wrapping 0→MOD-1.
- **tc:** `tick` && ((dir && q==MOD-1) || (!dir && q==0)). It is high in the same cycle as the wrapping tick.
- **Load:** has priority over `tick`.
  - `q` ← `load_val` if `load_val` < MOD, else MOD-1 (clamped).
  - `tc` is forced 0 on a load cycle.
  - Load does not affect `pre`.
- **Speed change:** `btn_speed` sets `speed` ← speed+1 (mod 4) and clears `pre` to 0 at the same edge, so the new rate starts cleanly.
- **Simultaneous events:** all button pulses apply independently at the same edge.
  - `tick`, `tc` and the count step use pre-edge values of `dir`, `speed` and `paused`. A tick coinciding with a toggle therefore still counts in the old direction.
  - A tick coinciding with a pause toggle still counts.
- **Widths:** all arithmetic is done at N bits. Wrap comparisons use MOD-1 and never rely on natural 2^N overflow.

## Timing
- Tick period is DIV_BASE >> speed cycles: 1×, 2×, 4×, 8× rate.
- First tick after reset release occurs on cycle L+1; `q` shows 1 the following cycle.
- Button-to-register latency is 1 cycle: `dir`, `speed` and `paused` change at the edge that samples the pulse.
- Resuming from pause continues from the held `pre` value. The remaining cycles to the next tick equal L − pre at the time of pause.
- Asserting `reset_n` low mid-operation clears all state immediately, without a clock. Deassertion is synchronised externally.

## Structure
- Package `counter_pkg`:
  - typedef `speed_t` (2-bit).
  - constants `DIR_UP`=1, `DIR_DOWN`=0.
  - constants `SPEED_1X`..`SPEED_8X`.
- Sub-module `tick_prescaler`:
  - parameter DIV_BASE.
  - inputs `clk`, `reset_n`, `speed`, `run`, `clear`.
  - output `tick`.
- The top level holds `dir`/`speed`/`paused` registers, the modulo counter and the load/clamp logic.

## Test plan
All scenarios use N=4, MOD=10, DIV_BASE=8.
- **Reset release, speed 0:** `tick` every 8 cycles; `q` steps 0..9. On the 10th tick `q` 9→0 with `tc`=1 for exactly that cycle.
- **Direction toggle:** `btn_ud` at q=3 → `dir`=0. Next ticks give 2, 1, 0, 9, with `tc`=1 on the 0→9 tick only.
- **Speed cycling:** three `btn_speed` pulses → `speed`=3, tick every cycle. A fourth pulse → `speed`=0, period 8, first tick 8 cycles after the pulse.
- **Pause:** `btn_pause` at q=5, pre=3 → no tick and q=5 held for 40 cycles. A second pulse resumes; the next tick comes exactly 4 cycles later.
- **Load:** `load`=1 with `load_val`=7 in the same cycle as a tick → q=7, `tc`=0. `load_val`=12 → q=9. `load_val`=9 while down-counting, then one tick → q=8.
- **Mid-operation reset:** from q=6, speed=2, dir=0, paused=1, `reset_n` low between edges → all outputs read reset values immediately. After release, counting restarts at period 8.
